// File: rtl/axis_rti_reader.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rti_reader
//  Purpose  : Drains one RTI line from BRAM port B onto an AXI4-Stream master,
//             optionally clearing each bin as it is read.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_rti_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_last,
    input  logic                  cfg_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_last;
    logic                  r_clear;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_b1_data;
    logic                  r_b1_valid;
    logic                  r_b1_last;

    logic       w_pop;
    logic [1:0] w_load;
    logic       w_credit;
    logic       w_issue;

    // The output head register plus r_b1 form the 2-entry buffer; a slot freed
    // by this cycle's handshake is already available as credit.
    assign w_pop    = m_axis_tvalid & m_axis_tready;
    assign w_load   = 2'(m_axis_tvalid) + 2'(r_b1_valid) + 2'(r_inflight);
    assign w_credit = (w_load - 2'(w_pop)) < 2'd2;
    assign w_issue  = (r_state == S_READ) & w_credit & ~rst;

    assign bram_en    = w_issue;
    assign bram_we    = w_issue & r_clear;
    assign bram_addr  = r_ptr;
    assign bram_wdata = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_last          <= '0;
            r_clear         <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_b1_data       <= '0;
            r_b1_valid      <= 1'b0;
            r_b1_last       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
        end else begin
            done       <= 1'b0;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_last <= (r_ptr == r_last);
            end

            if (w_pop) begin
                if (r_b1_valid) begin
                    m_axis_tdata  <= r_b1_data;
                    m_axis_tlast  <= r_b1_last;
                    m_axis_tvalid <= 1'b1;
                    r_b1_valid    <= r_inflight;
                    if (r_inflight) begin
                        r_b1_data <= bram_rdata;
                        r_b1_last <= r_inflight_last;
                    end
                end else begin
                    m_axis_tvalid <= r_inflight;
                    m_axis_tlast  <= r_inflight & r_inflight_last;
                    if (r_inflight) begin
                        m_axis_tdata <= bram_rdata;
                    end
                end
            end else if (!m_axis_tvalid) begin
                m_axis_tvalid <= r_inflight;
                m_axis_tlast  <= r_inflight & r_inflight_last;
                if (r_inflight) begin
                    m_axis_tdata <= bram_rdata;
                end
            end else if (r_inflight) begin
                r_b1_data  <= bram_rdata;
                r_b1_last  <= r_inflight_last;
                r_b1_valid <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    // A start coinciding with done is dropped.
                    if (start && !done) begin
                        r_last  <= cfg_last;
                        r_clear <= cfg_clear;
                        r_ptr   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        if (r_ptr == r_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && m_axis_tlast) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
